// File: rtl/gameover_fade_ctrl.sv
// gameover_fade_ctrl: fades the game-over screen in, holds it, fades it out, then pulses done
module gameover_fade_ctrl #(
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 120,
    parameter int CNT_W       = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       trigger,
    input  logic       skip,
    input  logic       frame_start,
    input  logic [4:0] index_in,
    input  logic       blank_in,
    output logic [4:0] palette_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       blank_out,
    output logic       screen_active,
    output logic [4:0] level,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, FADE_IN, HOLD, FADE_OUT, DONE} state_t;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic             blank_d;

    // upper nibble of the 8-bit product; level 16 returns c unchanged
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
        logic [7:0] p;
        p = {4'b0, c} * {3'b0, l};
        return p[7:4];
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            level         <= 5'd0;
            frame_cnt     <= '0;
            palette_index <= 5'd0;
            blank_d       <= 1'b1;
            blank_out     <= 1'b1;
            red           <= 4'd0;
            green         <= 4'd0;
            blue          <= 4'd0;
            screen_active <= 1'b0;
            done          <= 1'b0;
        end else begin
            palette_index <= index_in;
            blank_d       <= blank_in;
            blank_out     <= blank_d;
            red           <= blank_d ? 4'd0 : scale(pal_red, level);
            green         <= blank_d ? 4'd0 : scale(pal_green, level);
            blue          <= blank_d ? 4'd0 : scale(pal_blue, level);
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    level <= 5'd0;
                    if (trigger) begin
                        state         <= FADE_IN;
                        frame_cnt     <= '0;
                        screen_active <= 1'b1;
                    end
                end
                FADE_IN: begin
                    if (skip) begin
                        level     <= 5'd16;
                        state     <= HOLD;
                        frame_cnt <= '0;
                    end else if (frame_start) begin
                        if (frame_cnt == STEP_LAST) begin
                            frame_cnt <= '0;
                            level     <= level + 5'd1;
                            if (level == 5'd15) state <= HOLD;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (skip || (frame_start && frame_cnt == HOLD_LAST)) begin
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                    end else if (frame_start) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (frame_start) begin
                        if (frame_cnt == STEP_LAST) begin
                            frame_cnt <= '0;
                            level     <= level - 5'd1;
                            if (level == 5'd1) begin
                                state         <= DONE;
                                screen_active <= 1'b0;
                                done          <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gameover_fade_ctrl.md
Name: gameover_fade_ctrl

Overview:
- Sequences display of the game-over screen.
- On a trigger it fades the screen in from black, holds it for a set number of frames, fades it out, then pulses done.
- Sits between the game-over sprite ROM index stream and the VGA colour outputs.
- Drives the 5-bit index into the game-over palette lookup (combinational, 32 entries of 12-bit RGB), scales the returned colour by a brightness level, and registers the result.

Parameters:
- STEP_FRAMES, 4: frames per brightness step (≥1).
- HOLD_FRAMES, 120: frames held at full brightness (≥1).
- CNT_W, 8: width of the frame counter; must hold max(STEP_FRAMES, HOLD_FRAMES)-1.

Ports:
- Clk  in  1  system/pixel clock.
- Reset  in  1  synchronous, active-high reset.
- trigger  in  1  start sequence; honoured only in IDLE.
- skip  in  1  key press; shortens the sequence (see FSM).
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- index_in  in  5  palette index from the sprite ROM for the current pixel.
- blank_in  in  1  1 = pixel outside visible area.
- palette_index  out  5  index to the palette lookup.
- pal_red, pal_green, pal_blue  in  4 each  palette lookup result, combinational from palette_index.
- red, green, blue  out  4 each  scaled pixel colour.
- blank_out  out  1  blank_in delayed to align with red/green/blue.
- screen_active  out  1  1 in FADE_IN, HOLD and FADE_OUT.
- level  out  5  current brightness, 0..16.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, level=0, frame_cnt=0.
  - palette_index=0, red=green=blue=0, blank_out=1, screen_active=0, done=0.
  - Mid-sequence reset aborts with no done pulse.
- Pipeline, 2-cycle latency, always running:
  - Cycle 1: palette_index<=index_in, blank_d<=blank_in.
  - Cycle 2: colour outputs <= blank_d ? 0 : (pal_c * level) >> 4, per channel; 8-bit product, upper 4 bits kept; level 16 passes pal_c unchanged. blank_out<=blank_d.
  - level is sampled at cycle 2, so a level change takes effect on the next pixel.
- FSM:
  - IDLE: level=0. trigger -> FADE_IN, frame_cnt=0.
  - FADE_IN: on frame_start, if frame_cnt==STEP_FRAMES-1 then frame_cnt=0 and level+=1, else frame_cnt+=1. When level becomes 16 -> HOLD, frame_cnt=0. skip -> level=16, HOLD, frame_cnt=0.
  - HOLD: on frame_start, if frame_cnt==HOLD_FRAMES-1 -> FADE_OUT, frame_cnt=0, else frame_cnt+=1. skip -> FADE_OUT, frame_cnt=0.
  - FADE_OUT: mirrors FADE_IN with level-=1. When level becomes 0 -> DONE. skip is ignored.
  - DONE: done=1 for exactly one cycle -> IDLE. A trigger in DONE is ignored.
- Priority and boundary rules:
  - skip beats frame_start in the same cycle.
  - trigger outside IDLE is ignored.
  - level never leaves the range 0..16; no wrap.
  - Counters advance only on frame_start cycles.
  - screen_active is registered from the state: it rises the cycle after trigger and falls when DONE is entered.
- Nominal sequence length: 16*STEP_FRAMES + HOLD_FRAMES + 16*STEP_FRAMES frames.

Test Plan:
- Bench parameters: STEP_FRAMES=2, HOLD_FRAMES=3.
1. Reset with random inputs -> all outputs at reset values; blank_out=1; level=0; state IDLE.
2. trigger, then frame_start every 10 cycles -> level increments every 2nd frame_start and reaches 16 after 32 frame_starts. After 3 more frames FADE_OUT begins. level reaches 0 after 32 further frames. done pulses once; screen_active high throughout the sequence.
3. Colour scaling: index_in=7 with palette return F,F,0 -> at level 8, red/green/blue = 7,7,0 two cycles after index_in; at level 16 -> F,F,0; at level 0 -> 0,0,0. blank_in=1 -> 0,0,0 and blank_out=1 with the same 2-cycle delay.
4. skip at level 5 during FADE_IN -> next cycle level=16, state HOLD. A second skip -> FADE_OUT. skip during FADE_OUT -> no effect.
5. skip and frame_start in the same HOLD cycle -> FADE_OUT with frame_cnt=0. trigger during HOLD -> ignored, sequence unaffected.
6. Reset asserted in FADE_OUT at level 9 -> next cycle IDLE, level 0, no done pulse. A fresh trigger restarts from level 0.
